// File: rtl/mini16_mem_d_arbiter_if.sv
// mini16_mem_d_arbiter_if
//   Bundles the requester handshake and the memory bus of the arbiter.
//   Requester side : req, req_we, req_addr, req_wdata (packed per requester),
//                    req_mask, prio_en in; ack, rvalid, rdata out.
//   Memory side    : mem_r_addr, mem_w_addr, mem_w_data, mem_we out;
//                    mem_r_data in (valid one cycle after mem_r_addr).
//   Modports: master = the arbiter itself, slave = requesters + memory.
interface mini16_mem_d_arbiter_if #(
   parameter int N_REQ   = 4,
   parameter int WIDTH_D = 16,
   parameter int DEPTH_D = 8
);
   logic [N_REQ-1:0]         req;
   logic [N_REQ-1:0]         req_we;
   logic [N_REQ*DEPTH_D-1:0] req_addr;
   logic [N_REQ*WIDTH_D-1:0] req_wdata;
   logic [N_REQ-1:0]         req_mask;
   logic                     prio_en;
   logic [N_REQ-1:0]         ack;
   logic [N_REQ-1:0]         rvalid;
   logic [WIDTH_D-1:0]       rdata;
   logic [DEPTH_D-1:0]       mem_r_addr;
   logic [DEPTH_D-1:0]       mem_w_addr;
   logic [WIDTH_D-1:0]       mem_w_data;
   logic                     mem_we;
   logic [WIDTH_D-1:0]       mem_r_data;

   modport master (
      input  req, req_we, req_addr, req_wdata, req_mask, prio_en, mem_r_data,
      output ack, rvalid, rdata, mem_r_addr, mem_w_addr, mem_w_data, mem_we
   );

   modport slave (
      output req, req_we, req_addr, req_wdata, req_mask, prio_en, mem_r_data,
      input  ack, rvalid, rdata, mem_r_addr, mem_w_addr, mem_w_data, mem_we
   );
endinterface

// File: rtl/mini16_mem_d_arbiter.sv
// mini16_mem_d_arbiter
//   Round-robin arbiter giving N_REQ requesters shared access to one
//   synchronous memory port pair, one access per cycle. prio_en gives
//   requester 0 fixed top priority (loader mode).
//   Ports:
//     clk   - sole clock, posedge
//     reset - synchronous, active-high
//     bus   - mini16_mem_d_arbiter_if.master (requester handshake + memory bus)
//   Timing: pick in cycle N -> ack/mem_* registered for cycle N+1 ->
//   for reads, rvalid in cycle N+2 with rdata taken straight from mem_r_data.
module mini16_mem_d_arbiter #(
   parameter int N_REQ   = 4,
   parameter int WIDTH_D = 16,
   parameter int DEPTH_D = 8
) (
   input  logic clk,
   input  logic reset,
   mini16_mem_d_arbiter_if.master bus
);
   localparam int PTR_W = $clog2(N_REQ);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

   logic [DEPTH_D-1:0] addr_arr  [N_REQ];
   logic [WIDTH_D-1:0] wdata_arr [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = bus.req_addr[gi*DEPTH_D +: DEPTH_D];
         assign wdata_arr[gi] = bus.req_wdata[gi*WIDTH_D +: WIDTH_D];
      end
   endgenerate

   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [N_REQ-1:0]   rvalid_q, rvalid_d;
   logic               mem_we_q, mem_we_d;
   logic [DEPTH_D-1:0] mem_r_addr_q, mem_r_addr_d;
   logic [DEPTH_D-1:0] mem_w_addr_q, mem_w_addr_d;
   logic [WIDTH_D-1:0] mem_w_data_q, mem_w_data_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic [N_REQ-1:0]   elig;
   logic               pick_valid;
   logic [PTR_W-1:0]   pick_idx;
   logic [PTR_W:0]     cand;

   // A requester acked this cycle sits out one cycle, which is what
   // spreads back-to-back service across the other requesters.
   assign elig = bus.req & ~bus.req_mask & ~ack_q;

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      if (bus.prio_en && elig[0]) begin
         pick_valid = 1'b1;
      end else begin
         // Walk the distances from far to near so the nearest eligible
         // index after rr_ptr is the one left standing.
         for (int k = N_REQ; k >= 1; k--) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N_REQ)) begin
               cand = cand - (PTR_W+1)'(N_REQ);
            end
            if (elig[cand[PTR_W-1:0]]) begin
               pick_valid = 1'b1;
               pick_idx   = cand[PTR_W-1:0];
            end
         end
      end
   end

   always_comb begin
      ack_d        = '0;
      mem_we_d     = 1'b0;
      mem_r_addr_d = mem_r_addr_q;
      mem_w_addr_d = mem_w_addr_q;
      mem_w_data_d = mem_w_data_q;
      rr_ptr_d     = rr_ptr_q;
      // The read issued this cycle returns data next cycle.
      rvalid_d     = mem_we_q ? '0 : ack_q;
      if (pick_valid) begin
         ack_d[pick_idx] = 1'b1;
         mem_we_d        = bus.req_we[pick_idx];
         mem_r_addr_d    = addr_arr[pick_idx];
         mem_w_addr_d    = addr_arr[pick_idx];
         mem_w_data_d    = wdata_arr[pick_idx];
         rr_ptr_d        = pick_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_q        <= '0;
         rvalid_q     <= '0;
         mem_we_q     <= 1'b0;
         mem_r_addr_q <= '0;
         mem_w_addr_q <= '0;
         mem_w_data_q <= '0;
         rr_ptr_q     <= PTR_LAST;
      end else begin
         ack_q        <= ack_d;
         rvalid_q     <= rvalid_d;
         mem_we_q     <= mem_we_d;
         mem_r_addr_q <= mem_r_addr_d;
         mem_w_addr_q <= mem_w_addr_d;
         mem_w_data_q <= mem_w_data_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign bus.ack        = ack_q;
   assign bus.rvalid     = rvalid_q;
   assign bus.rdata      = bus.mem_r_data;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_r_addr = mem_r_addr_q;
   assign bus.mem_w_addr = mem_w_addr_q;
   assign bus.mem_w_data = mem_w_data_q;
endmodule
